fb_reader: RTL

//   Read-side counterpart of the frame-buffer pixel writer: accepts pixel addresses on an
//   AXI-stream style handshake and issues AXI-lite reads to the SRAM frame buffer.
//   It returns {addr, color} in request order on an output stream.

---
 rtl/fb_reader.sv | 120 ++++++++++++
 1 files changed

// File: rtl/fb_reader.sv
// fb_reader: turns a stream of pixel addresses into AXI-lite reads of the
// SRAM frame buffer. It returns {addr, color, err} in request order on an
// output stream. One shared occupancy count of DEPTH bounds the reads that
// are in flight plus the reads that are buffered. Because of that bound,
// R beats can always be accepted.
module fb_reader #(
    parameter int PIXEL_BITS     = 12,
    parameter int AXI_ADDR_WIDTH = 20,
    parameter int AXI_DATA_WIDTH = 16,
    parameter int DEPTH          = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      axi_tvalid,
    output logic                      axi_tready,
    input  logic [AXI_ADDR_WIDTH-1:0] addr,
    output logic                      pixel_tvalid,
    input  logic                      pixel_tready,
    output logic [AXI_ADDR_WIDTH-1:0] pixel_addr,
    output logic [PIXEL_BITS-1:0]     pixel_color,
    output logic                      pixel_err,
    output logic [AXI_ADDR_WIDTH-1:0] sram_axi_araddr,
    output logic                      sram_axi_arvalid,
    input  logic                      sram_axi_arready,
    input  logic [AXI_DATA_WIDTH-1:0] sram_axi_rdata,
    input  logic [1:0]                sram_axi_rresp,
    input  logic                      sram_axi_rvalid,
    output logic                      sram_axi_rready
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [AXI_ADDR_WIDTH-1:0] addr_mem [DEPTH];
    logic [PIXEL_BITS:0]       data_mem [DEPTH];
    logic [PW-1:0]             awr_ptr;
    logic [PW-1:0]             dwr_ptr;
    logic [PW-1:0]             rd_ptr;
    logic [CW-1:0]             acount;
    logic [CW-1:0]             dcount;
    logic                      afull;
    logic                      ar_fire;
    logic                      r_push;
    logic                      pix_pop;

    // The address FIFO count doubles as the credit counter. When it is full,
    // requests are blocked. This holds even if a pixel leaves in the same cycle.
    assign afull            = (acount == CW'(DEPTH));
    assign sram_axi_araddr  = addr;
    assign sram_axi_arvalid = axi_tvalid & ~afull & ~reset;
    assign axi_tready       = sram_axi_arready & ~afull & ~reset;
    assign sram_axi_rready  = ~reset;
    assign ar_fire          = sram_axi_arvalid & sram_axi_arready;

    // An R beat with nothing outstanding (equal counts) is dropped.
    assign r_push  = sram_axi_rvalid & sram_axi_rready & (acount != dcount);
    assign pixel_tvalid = (dcount != '0);
    assign pix_pop = pixel_tvalid & pixel_tready;

    // Both FIFOs pop together, so they share one read pointer.
    assign pixel_addr = addr_mem[rd_ptr];
    assign {pixel_err, pixel_color} = data_mem[rd_ptr];

    // Address FIFO: push on the AR handshake, pop when a pixel is consumed
    always_ff @(posedge clk) begin
        if (reset) begin
            awr_ptr <= '0;
            acount  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                addr_mem[i] <= '0;
            end
        end else begin
            if (ar_fire) begin
                addr_mem[awr_ptr] <= addr;
                awr_ptr           <= awr_ptr + PW'(1);
            end
            if (ar_fire && !pix_pop) begin
                acount <= acount + CW'(1);
            end else if (!ar_fire && pix_pop) begin
                acount <= acount - CW'(1);
            end
        end
    end

    // Data FIFO: capture {err, color} from each accepted R beat
    always_ff @(posedge clk) begin
        if (reset) begin
            dwr_ptr <= '0;
            dcount  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                data_mem[i] <= '0;
            end
        end else begin
            if (r_push) begin
                data_mem[dwr_ptr] <= {(|sram_axi_rresp),
                                      sram_axi_rdata[AXI_DATA_WIDTH-1 -: PIXEL_BITS]};
                dwr_ptr           <= dwr_ptr + PW'(1);
            end
            if (r_push && !pix_pop) begin
                dcount <= dcount + CW'(1);
            end else if (!r_push && pix_pop) begin
                dcount <= dcount - CW'(1);
            end
        end
    end

    // Shared read pointer advances on every pixel handshake
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
        end else if (pix_pop) begin
            rd_ptr <= rd_ptr + PW'(1);
        end
    end

    // An R beat is only legal while a read is outstanding
    assert property (@(posedge clk) disable iff (reset)
                     !(sram_axi_rvalid && (acount == dcount)));

endmodule
